// File: rtl/ddr_fb_pkg.sv
// ddr_fb_pkg: shared frame-buffer geometry defaults and packer state encoding.
package ddr_fb_pkg;
    localparam int PIX_WIDTH   = 16;
    localparam int DATA_WIDTH  = 256;
    localparam int FRAME_WORDS = 49152;
    typedef enum logic [1:0] {WAIT_VS, ACTIVE, FULL} state_t;
endpackage

// File: rtl/vs_edge_det.sv
// vs_edge_det: registers vsync once and flags its rising edge combinationally.
module vs_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_vs,
    output logic o_vs_d,
    output logic o_rise
);
    logic r_vs;
    always_ff @(posedge i_clk) begin
        if (i_rst) r_vs <= 1'b0;
        else       r_vs <= i_vs;
    end
    assign o_vs_d = r_vs;
    assign o_rise = i_vs & ~r_vs;
endmodule

// File: rtl/cmos_pixel_packer.sv
// cmos_pixel_packer: packs pixels into wide frame-buffer words, aligning each frame to vsync.
module cmos_pixel_packer #(
    parameter int PIX_WIDTH   = ddr_fb_pkg::PIX_WIDTH,
    parameter int DATA_WIDTH  = ddr_fb_pkg::DATA_WIDTH,
    parameter int FRAME_WORDS = ddr_fb_pkg::FRAME_WORDS
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_pix_vs,
    input  logic                  i_pix_de,
    input  logic [PIX_WIDTH-1:0]  i_pix_data,
    output logic                  o_sys_we,
    output logic [DATA_WIDTH-1:0] o_sys_data_in,
    output logic                  o_vin_vs,
    output logic                  o_frame_done,
    output logic [15:0]           o_word_cnt,
    output logic                  o_frame_err,
    output logic [7:0]            o_drop_cnt
);
    import ddr_fb_pkg::*;
    localparam int LANES = DATA_WIDTH / PIX_WIDTH;
    localparam int LW = $clog2(LANES);
    localparam logic [LW-1:0] LANE_MAX = LW'(LANES - 1);
    localparam logic [15:0] LAST_WORD = 16'(FRAME_WORDS - 1);

    state_t                r_state;
    logic [LW-1:0]         r_lane;
    logic [DATA_WIDTH-1:0] r_stage;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_we;
    logic                  r_done;
    logic [15:0]           r_word_cnt;
    logic                  r_err;
    logic [7:0]            r_drop;
    logic                  r_ovr;
    logic                  w_rise;
    logic                  w_accept;
    logic [LW-1:0]         w_lane;
    logic [DATA_WIDTH-1:0] w_stage;
    logic [7:0]            w_drop_inc;

    vs_edge_det u_vs (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_vs   (i_pix_vs),
        .o_vs_d (o_vin_vs),
        .o_rise (w_rise)
    );

    // A pixel coincident with the vsync rise lands in lane 0 of the new frame.
    assign w_lane     = w_rise ? '0 : r_lane;
    assign w_accept   = i_pix_de && (w_rise || r_state == ACTIVE);
    assign w_drop_inc = r_drop + {7'd0, ~&r_drop};

    always_comb begin
        w_stage = r_stage;
        w_stage[w_lane*PIX_WIDTH +: PIX_WIDTH] = i_pix_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= WAIT_VS;
            r_lane     <= '0;
            r_stage    <= '0;
            r_data     <= '0;
            r_we       <= 1'b0;
            r_done     <= 1'b0;
            r_word_cnt <= '0;
            r_err      <= 1'b0;
            r_drop     <= '0;
            r_ovr      <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            if (w_rise) begin
                r_state    <= ACTIVE;
                r_lane     <= '0;
                r_word_cnt <= '0;
                r_ovr      <= 1'b0;
                if (r_state == ACTIVE) begin
                    r_err  <= 1'b1;
                    r_drop <= w_drop_inc;
                end
            end
            if (w_accept) begin
                r_stage <= w_stage;
                r_lane  <= w_lane + 1'b1;
                if (w_lane == LANE_MAX) begin
                    r_data     <= w_stage;
                    r_we       <= 1'b1;
                    r_word_cnt <= r_word_cnt + 16'd1;
                    if (r_word_cnt == LAST_WORD) begin
                        r_done  <= 1'b1;
                        r_state <= FULL;
                    end
                end
            end
            // Overrun is reported once per frame, however many extra pixels arrive.
            if (!w_rise && r_state == FULL && i_pix_de && !r_ovr) begin
                r_ovr  <= 1'b1;
                r_err  <= 1'b1;
                r_drop <= w_drop_inc;
            end
        end
    end

    assign o_sys_we      = r_we;
    assign o_sys_data_in = r_data;
    assign o_frame_done  = r_done;
    assign o_word_cnt    = r_word_cnt;
    assign o_frame_err   = r_err;
    assign o_drop_cnt    = r_drop;
endmodule
